// File: rtl/wb_master_bridge_if.sv
// wb_master_bridge_if: command/response port plus Wishbone classic bus.
// master = bridge view, slave = command source / peripheral side view.
interface wb_master_bridge_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_dat;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;

    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat,
        input  rsp_ready, wb_dat_i, wb_ack_i,
        output cmd_ready, rsp_valid, rsp_dat, rsp_err,
        output wb_cyc_o, wb_stb_o, wb_we_o,
        output wb_adr_o, wb_sel_o, wb_dat_o
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat,
        output rsp_ready, wb_dat_i, wb_ack_i,
        input  cmd_ready, rsp_valid, rsp_dat, rsp_err,
        input  wb_cyc_o, wb_stb_o, wb_we_o,
        input  wb_adr_o, wb_sel_o, wb_dat_o
    );
endinterface

// File: rtl/wb_master_bridge.sv
// wb_master_bridge: turns single valid/ready commands into Wishbone
// classic single cycles, with bus timeout and a valid/ready response.
module wb_master_bridge #(
    parameter int unsigned timeout_cycles = 255,
    parameter bit          write_rsp      = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    wb_master_bridge_if.master bus,
    output logic               busy
);
    localparam int unsigned cnt_w =
        (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    localparam int unsigned last_cnt =
        (timeout_cycles == 0) ? 0 : timeout_cycles - 1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(last_cnt);
    localparam bit tmo_en = (timeout_cycles != 0);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [cnt_w-1:0] cnt_q;
    logic             accept;
    logic             ack_hit;
    logic             tmo_hit;

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign busy          = (state_q != IDLE);

    // next state; ack on the terminal-count edge wins over timeout
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        ack_hit = 1'b0;
        tmo_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (bus.wb_ack_i) begin
                    ack_hit = 1'b1;
                    if (bus.wb_we_o && !write_rsp)
                        state_d = IDLE;
                    else
                        state_d = RESP;
                end else if (tmo_en && cnt_q == cnt_last) begin
                    tmo_hit = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // registered bus outputs, timeout counter and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wb_cyc_o <= 1'b0;
            bus.wb_stb_o <= 1'b0;
            bus.wb_we_o  <= 1'b0;
            bus.wb_adr_o <= '0;
            bus.wb_sel_o <= '0;
            bus.wb_dat_o <= '0;
            bus.rsp_dat  <= '0;
            bus.rsp_err  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (accept) begin
                bus.wb_we_o  <= bus.cmd_we;
                bus.wb_adr_o <= bus.cmd_adr;
                bus.wb_sel_o <= bus.cmd_sel;
                bus.wb_dat_o <= bus.cmd_we ? bus.cmd_dat : 32'h0;
                bus.wb_cyc_o <= 1'b1;
                bus.wb_stb_o <= 1'b1;
                cnt_q        <= '0;
            end else if (ack_hit || tmo_hit) begin
                bus.wb_cyc_o <= 1'b0;
                bus.wb_stb_o <= 1'b0;
                bus.rsp_err  <= tmo_hit;
                if (ack_hit && !bus.wb_we_o)
                    bus.rsp_dat <= bus.wb_dat_i;
                else
                    bus.rsp_dat <= 32'h0;
            end else if (state_q == BUS && tmo_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_master_bridge.sv
// tb_wb_master_bridge: directed vectors and corner sequences for the
// Wishbone bridge, with a registered-ack slave model on each instance.
module tb_wb_master_bridge;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_master_bridge_if b();
    wb_master_bridge_if c();
    logic busy_b;
    logic busy_c;

    wb_master_bridge #(.timeout_cycles(8), .write_rsp(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(b), .busy(busy_b));
    wb_master_bridge #(.timeout_cycles(8), .write_rsp(1'b0)) dut_c (
        .clk(clk), .reset(reset), .bus(c), .busy(busy_c));

    // slave on b: ack one cycle after stb, read data = adr + 0xA3
    logic        ack_en;
    logic        inj_ack;
    logic        auto_ack;
    int          wr_cnt;
    int          stb_cnt;
    assign b.wb_ack_i = auto_ack | inj_ack;
    assign b.wb_dat_i = b.wb_ack_i ? (b.wb_adr_o + 32'hA3) : 32'hDEAD_BEEF;

    // b slave handshake and write/strobe bookkeeping
    always @(posedge clk) begin
        if (reset) begin
            auto_ack <= 1'b0;
            wr_cnt   <= 0;
            stb_cnt  <= 0;
        end else begin
            auto_ack <= ack_en & b.wb_cyc_o & b.wb_stb_o & ~auto_ack;
            if (b.wb_cyc_o & b.wb_stb_o & b.wb_ack_i & b.wb_we_o)
                wr_cnt <= wr_cnt + 1;
            if (b.wb_stb_o)
                stb_cnt <= stb_cnt + 1;
        end
    end

    // slave on c
    logic        c_ack_en;
    logic        c_ack;
    int          c_wr_cnt;
    int          c_rv_cnt;
    logic [31:0] c_wdat;
    assign c.wb_ack_i = c_ack;
    assign c.wb_dat_i = 32'h0000_0055;

    // c slave handshake, write capture and response counting
    always @(posedge clk) begin
        if (reset) begin
            c_ack    <= 1'b0;
            c_wr_cnt <= 0;
            c_rv_cnt <= 0;
            c_wdat   <= '0;
        end else begin
            c_ack <= c_ack_en & c.wb_cyc_o & c.wb_stb_o & ~c_ack;
            if (c.wb_cyc_o & c.wb_stb_o & c_ack & c.wb_we_o) begin
                c_wr_cnt <= c_wr_cnt + 1;
                c_wdat   <= c.wb_dat_o;
            end
            if (c.rsp_valid)
                c_rv_cnt <= c_rv_cnt + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd_b(input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat);
        b.cmd_valid = 1'b1;
        b.cmd_we    = we;
        b.cmd_adr   = adr;
        b.cmd_sel   = sel;
        b.cmd_dat   = dat;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    vec_t        vec [5];
    int          w0;
    int          s0;
    int          n;
    int          nxt;
    int          got;
    int          low_run;
    int          min_gap;
    logic        seen;
    logic        acc;
    logic [31:0] b2b_adr [4];
    logic [31:0] b2b_exp [4];

    initial begin
        vec[0] = '{1'b0, 32'h0000_0008, 4'hF, 32'h0,         32'h0000_00AB};
        vec[1] = '{1'b1, 32'h0000_0004, 4'hF, 32'h0000_1000, 32'h0};
        vec[2] = '{1'b0, 32'h0000_0100, 4'h3, 32'h0,         32'h0000_01A3};
        vec[3] = '{1'b1, 32'h0000_0020, 4'h1, 32'hCAFE_F00D, 32'h0};
        vec[4] = '{1'b0, 32'hFFFF_FFF0, 4'h8, 32'h0,         32'h0000_0093};
        b2b_adr = '{32'h10, 32'h14, 32'h18, 32'h1C};
        b2b_exp = '{32'hB3, 32'hB7, 32'hBB, 32'hBF};

        reset = 1'b1;
        ack_en = 1'b1; inj_ack = 1'b0; c_ack_en = 1'b1;
        b.cmd_valid = 1'b0; b.cmd_we = 1'b0; b.cmd_adr = '0;
        b.cmd_sel = '0; b.cmd_dat = '0; b.rsp_ready = 1'b1;
        c.cmd_valid = 1'b0; c.cmd_we = 1'b0; c.cmd_adr = '0;
        c.cmd_sel = '0; c.cmd_dat = '0; c.rsp_ready = 1'b1;
        tick(); tick(); tick();
        chk("rst_cyc_stb", {b.wb_cyc_o, b.wb_stb_o, b.wb_we_o}, 3'b000);
        chk("rst_adr", b.wb_adr_o, 32'h0);
        chk("rst_sel", b.wb_sel_o, 4'h0);
        chk("rst_dat_o", b.wb_dat_o, 32'h0);
        chk("rst_rsp", {b.rsp_valid, b.rsp_err}, 2'b00);
        chk("rst_rsp_dat", b.rsp_dat, 32'h0);
        chk("rst_ready_busy", {b.cmd_ready, busy_b}, 2'b10);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) begin
            w0 = wr_cnt;
            cmd_b(vec[k].we, vec[k].adr, vec[k].sel, vec[k].dat);
            chk("v_ready", b.cmd_ready, 1'b1);
            tick();
            b.cmd_valid = 1'b0; b.cmd_we = ~vec[k].we;
            b.cmd_adr = 32'h5555_5555; b.cmd_dat = 32'hAAAA_AAAA;
            b.cmd_sel = 4'h0;
            chk("v_cyc_stb1", {b.wb_cyc_o, b.wb_stb_o}, 2'b11);
            chk("v_adr", b.wb_adr_o, vec[k].adr);
            chk("v_we", b.wb_we_o, vec[k].we);
            chk("v_sel", b.wb_sel_o, vec[k].sel);
            chk("v_dat_o", b.wb_dat_o, vec[k].we ? vec[k].dat : 32'h0);
            chk("v_busy", {b.cmd_ready, busy_b}, 2'b01);
            tick();
            chk("v_stb2", b.wb_stb_o, 1'b1);
            chk("v_hold", b.wb_dat_o, vec[k].we ? vec[k].dat : 32'h0);
            chk("v_no_rsp", b.rsp_valid, 1'b0);
            tick();
            chk("v_stb_low", {b.wb_cyc_o, b.wb_stb_o}, 2'b00);
            chk("v_rsp_valid", b.rsp_valid, 1'b1);
            chk("v_rsp_dat", b.rsp_dat, vec[k].exp);
            chk("v_rsp_err", b.rsp_err, 1'b0);
            chk("v_writes", wr_cnt - w0, {31'h0, vec[k].we});
            tick();
            chk("v_done", {b.rsp_valid, b.cmd_ready}, 2'b01);
        end

        inj_ack = 1'b1;
        tick(); tick();
        chk("idle_ack", {b.rsp_valid, busy_b, b.wb_stb_o}, 3'b000);
        inj_ack = 1'b0;

        ack_en = 1'b0;
        s0 = stb_cnt;
        cmd_b(1'b0, 32'h40, 4'hF, 32'h0);
        tick();
        b.cmd_valid = 1'b0;
        n = 0;
        while (!b.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("to_latency", n, 8);
        chk("to_stb_cycles", stb_cnt - s0, 8);
        chk("to_err", b.rsp_err, 1'b1);
        chk("to_dat", b.rsp_dat, 32'h0);
        chk("to_stb_low", b.wb_stb_o, 1'b0);
        tick();
        chk("to_done", b.cmd_ready, 1'b1);

        cmd_b(1'b0, 32'h40, 4'hF, 32'h0);
        tick();
        b.cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("late_stb", b.wb_stb_o, 1'b1);
        inj_ack = 1'b1;
        tick();
        inj_ack = 1'b0;
        chk("late_valid", b.rsp_valid, 1'b1);
        chk("late_err", b.rsp_err, 1'b0);
        chk("late_dat", b.rsp_dat, 32'hE3);
        tick();
        ack_en = 1'b1;

        b.rsp_ready = 1'b0;
        cmd_b(1'b0, 32'h30, 4'hF, 32'h0);
        tick();
        b.cmd_valid = 1'b0;
        tick(); tick();
        cmd_b(1'b0, 32'h34, 4'hF, 32'h0);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", b.rsp_valid, 1'b1);
            chk("bp_dat", b.rsp_dat, 32'hD3);
            chk("bp_ready_stb", {b.cmd_ready, b.wb_stb_o}, 2'b00);
            tick();
        end
        b.rsp_ready = 1'b1;
        tick();
        chk("bp_release", {b.cmd_ready, b.rsp_valid, b.wb_stb_o}, 3'b100);
        tick();
        b.cmd_valid = 1'b0;
        chk("bp_next_stb", b.wb_stb_o, 1'b1);
        chk("bp_next_adr", b.wb_adr_o, 32'h34);
        tick(); tick();
        chk("bp_next_dat", b.rsp_dat, 32'hD7);
        tick();

        nxt = 0; got = 0; low_run = 0; min_gap = 99; seen = 1'b0;
        cmd_b(1'b0, b2b_adr[0], 4'hF, 32'h0);
        for (int i = 0; i < 40 && got < 4; i++) begin
            acc = b.cmd_valid & b.cmd_ready;
            if (b.rsp_valid) begin
                chk("b2b_dat", b.rsp_dat, b2b_exp[got]);
                got++;
            end
            if (b.wb_stb_o) begin
                if (seen && low_run > 0 && low_run < min_gap)
                    min_gap = low_run;
                if (seen && low_run == 0 && !busy_b)
                    min_gap = 0;
                seen = 1'b1;
                low_run = 0;
            end else if (seen) begin
                low_run++;
            end
            tick();
            if (acc) begin
                nxt++;
                if (nxt < 4) b.cmd_adr = b2b_adr[nxt];
                else b.cmd_valid = 1'b0;
            end
        end
        b.cmd_valid = 1'b0;
        chk("b2b_count", got, 4);
        chk("b2b_gap_ok", (min_gap >= 1 && min_gap < 99) ? 1 : 0, 1);

        ack_en = 1'b0;
        cmd_b(1'b0, 32'h44, 4'hF, 32'h0);
        tick();
        b.cmd_valid = 1'b0;
        tick();
        chk("rb_stb_high", b.wb_stb_o, 1'b1);
        reset = 1'b1;
        tick();
        chk("rb_cyc_stb", {b.wb_cyc_o, b.wb_stb_o}, 2'b00);
        chk("rb_no_rsp", {b.rsp_valid, busy_b}, 2'b00);
        reset = 1'b0;
        ack_en = 1'b1;
        tick();
        chk("rb_ready", b.cmd_ready, 1'b1);
        tick(); tick();
        chk("rb_still_no_rsp", b.rsp_valid, 1'b0);

        c.cmd_valid = 1'b1; c.cmd_we = 1'b1; c.cmd_adr = 32'h4;
        c.cmd_sel = 4'hF; c.cmd_dat = 32'h0000_1000;
        tick();
        c.cmd_valid = 1'b0; c.cmd_dat = 32'h0;
        chk("c_dat_o1", c.wb_dat_o, 32'h1000);
        tick();
        chk("c_dat_o2", {c.wb_stb_o, c.wb_dat_o[31:0]}, {1'b1, 32'h1000});
        tick();
        chk("c_ready_back", {c.cmd_ready, c.rsp_valid, c.wb_stb_o}, 3'b100);
        chk("c_writes", c_wr_cnt, 1);
        chk("c_wdat", c_wdat, 32'h1000);
        tick();
        chk("c_no_rsp", c_rv_cnt, 0);

        c_ack_en = 1'b0;
        c.cmd_valid = 1'b1; c.cmd_adr = 32'h8; c.cmd_dat = 32'h77;
        tick();
        c.cmd_valid = 1'b0;
        n = 0;
        while (!c.rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("c_to_latency", n, 8);
        chk("c_to_err", {c.rsp_err, c.rsp_dat[31:0]}, {1'b1, 32'h0});
        tick();
        chk("c_to_done", c.cmd_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
